// File: rtl/onehot_scan_decoder_pkg.sv
// Shared definitions for the one-hot scan decoder.
//   out_w()     : number of one-hot lines for a given code width (2**sel_w)
//   DEC_DIRECT  : mode value for direct (load-on-request) decoding
//   DEC_SCAN    : mode value for autonomous scanning with a programmable dwell
package onehot_scan_decoder_pkg;

  localparam logic DEC_DIRECT = 1'b0;
  localparam logic DEC_SCAN   = 1'b1;

  // Stands in for OUT_W = 2**SEL_W wherever SEL_W is a module parameter.
  function automatic int unsigned out_w(int unsigned sel_w);
    return 32'd1 << sel_w;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Combinational binary-to-one-hot decoder, the generalised 2-to-4 decoder.
//   code   in  SEL_W        binary code
//   onehot out 2**SEL_W     bit [code] set, all others clear
module onehot_dec
  import onehot_scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W = 2
) (
  input  logic [SEL_W-1:0]        code,
  output logic [out_w(SEL_W)-1:0] onehot
);

  always_comb begin
    onehot       = '0;
    onehot[code] = 1'b1;
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered binary-to-one-hot decoder with direct and scan modes.
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   1 runs the block; 0 freezes state and blanks dout
//   mode      in   DEC_DIRECT (load on request) or DEC_SCAN (auto-step)
//   load      in   single-cycle request to load code
//   code      in   code to load
//   dout      out  registered one-hot of cur_code (inverted if ACTIVE_LOW)
//   cur_code  out  code currently decoded
//   valid     out  1 when dout carries a decoded code
//   wrap      out  one-cycle pulse when scan steps from LAST to 0
module onehot_scan_decoder
  import onehot_scan_decoder_pkg::*;
#(
  parameter int unsigned SEL_W      = 2,
  parameter int unsigned LAST       = (1 << SEL_W) - 1,
  parameter int unsigned DWELL      = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  input  logic                    load,
  input  logic [SEL_W-1:0]        code,
  output logic [out_w(SEL_W)-1:0] dout,
  output logic [SEL_W-1:0]        cur_code,
  output logic                    valid,
  output logic                    wrap
);

  localparam int unsigned OUT_W   = out_w(SEL_W);
  localparam int unsigned DWELL_W = (DWELL > 1) ? $clog2(DWELL) : 1;

  localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(DWELL - 1);
  localparam logic [SEL_W-1:0]   LAST_CODE = SEL_W'(LAST);
  localparam logic [OUT_W-1:0]   IDLE      = {OUT_W{ACTIVE_LOW}};

  logic [SEL_W-1:0]   cur_code_q, cur_code_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic               mode_q, mode_d;
  logic               valid_q, valid_d;
  logic               wrap_q, wrap_d;
  logic [OUT_W-1:0]   dout_q, dout_d;
  logic [OUT_W-1:0]   dec_onehot;

  // Next-state for code, dwell counter and remembered mode.
  // mode_q only tracks mode while enabled, so a mode change made during a
  // freeze is seen as a change on the first enabled cycle.
  always_comb begin
    cur_code_d = cur_code_q;
    dwell_d    = dwell_q;
    mode_d     = mode_q;
    wrap_d     = 1'b0;
    if (en) begin
      mode_d = mode;
      if (mode == DEC_DIRECT) begin
        dwell_d = '0;
        if (load) begin
          cur_code_d = code;
        end
      end else if (load) begin
        // Load beats a same-cycle step; out-of-range codes restart the scan.
        dwell_d    = '0;
        cur_code_d = (code > LAST_CODE) ? '0 : code;
      end else if (mode != mode_q) begin
        dwell_d = '0;
      end else if (dwell_q == DWELL_MAX) begin
        dwell_d    = '0;
        wrap_d     = (cur_code_q == LAST_CODE);
        cur_code_d = (cur_code_q >= LAST_CODE) ? '0 : cur_code_q + SEL_W'(1);
      end else begin
        dwell_d = dwell_q + DWELL_W'(1);
      end
    end
  end

  // Decode the next code so dout lines up with cur_code after the edge.
  onehot_dec #(
    .SEL_W (SEL_W)
  ) u_dec (
    .code   (cur_code_d),
    .onehot (dec_onehot)
  );

  always_comb begin
    valid_d = en;
    dout_d  = en ? dec_onehot : '0;
    if (ACTIVE_LOW) begin
      dout_d = ~dout_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_code_q <= '0;
      dwell_q    <= '0;
      mode_q     <= DEC_DIRECT;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      dout_q     <= IDLE;
    end else begin
      cur_code_q <= cur_code_d;
      dwell_q    <= dwell_d;
      mode_q     <= mode_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      dout_q     <= dout_d;
    end
  end

  assign dout     = dout_q;
  assign cur_code = cur_code_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
module tb_onehot_scan_decoder;

  localparam int NDUT   = 3;
  localparam int NCYC   = 3000;
  // Configurations: A = SEL_W 2, LAST 2, DWELL 3; B = SEL_W 3, LAST 5, DWELL 2, active-low;
  // C = SEL_W 2, LAST 0, DWELL 1.
  localparam int P_SEL   [NDUT] = '{2, 3, 2};
  localparam int P_LAST  [NDUT] = '{2, 5, 0};
  localparam int P_DWELL [NDUT] = '{3, 2, 1};
  localparam int P_AL    [NDUT] = '{0, 1, 0};

  typedef struct packed {
    int                        cyc;
    logic [NDUT-1:0][7:0]      dout;
    logic [NDUT-1:0][2:0]      cur;
    logic [NDUT-1:0]           valid;
    logic [NDUT-1:0]           wrap;
  } exp_t;

  logic       clk, rst_n, en, mode, load;
  logic [2:0] code;

  logic [3:0] dout_a, dout_c;
  logic [7:0] dout_b;
  logic [1:0] cur_a, cur_c;
  logic [2:0] cur_b;
  logic       valid_a, valid_b, valid_c, wrap_a, wrap_b, wrap_c;

  onehot_scan_decoder #(.SEL_W(2), .LAST(2), .DWELL(3), .ACTIVE_LOW(1'b0)) dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .code(code[1:0]),
    .dout(dout_a), .cur_code(cur_a), .valid(valid_a), .wrap(wrap_a)
  );

  onehot_scan_decoder #(.SEL_W(3), .LAST(5), .DWELL(2), .ACTIVE_LOW(1'b1)) dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .code(code),
    .dout(dout_b), .cur_code(cur_b), .valid(valid_b), .wrap(wrap_b)
  );

  onehot_scan_decoder #(.SEL_W(2), .LAST(0), .DWELL(1), .ACTIVE_LOW(1'b0)) dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .load(load), .code(code[1:0]),
    .dout(dout_c), .cur_code(cur_c), .valid(valid_c), .wrap(wrap_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: current code plus the number of cycles it still has to be held.
  int m_cur [NDUT];
  int m_left[NDUT];
  bit m_pmode[NDUT];
  bit m_valid[NDUT];
  bit m_wrap [NDUT];

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  task automatic model_reset();
    for (int k = 0; k < NDUT; k++) begin
      m_cur[k]   = 0;
      m_left[k]  = P_DWELL[k];
      m_pmode[k] = 1'b0;
      m_valid[k] = 1'b0;
      m_wrap[k]  = 1'b0;
    end
  endtask

  task automatic model_step(input bit e, input bit md, input bit ld, input int cd);
    for (int k = 0; k < NDUT; k++) begin
      int c;
      c = cd % (1 << P_SEL[k]);
      m_wrap[k]  = 1'b0;
      m_valid[k] = e;
      if (e) begin
        if (!md) begin
          m_left[k] = P_DWELL[k];
          if (ld) m_cur[k] = c;
        end else if (ld) begin
          m_cur[k]  = (c > P_LAST[k]) ? 0 : c;
          m_left[k] = P_DWELL[k];
        end else if (md != m_pmode[k]) begin
          m_left[k] = P_DWELL[k];
        end else if (m_left[k] == 1) begin
          m_wrap[k] = (m_cur[k] == P_LAST[k]);
          m_cur[k]  = (m_cur[k] >= P_LAST[k]) ? 0 : m_cur[k] + 1;
          m_left[k] = P_DWELL[k];
        end else begin
          m_left[k] = m_left[k] - 1;
        end
        m_pmode[k] = md;
      end
    end
  endtask

  function automatic exp_t make_exp(input int cy);
    exp_t x;
    x.cyc = cy;
    for (int k = 0; k < NDUT; k++) begin
      int d;
      d = m_valid[k] ? (1 << m_cur[k]) : 0;
      if (P_AL[k] != 0) d = d ^ ((1 << (1 << P_SEL[k])) - 1);
      x.dout[k]  = 8'(d);
      x.cur[k]   = 3'(m_cur[k]);
      x.valid[k] = m_valid[k];
      x.wrap[k]  = m_wrap[k];
    end
    return x;
  endfunction

  task automatic check(input string name, input int k, input int cy, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s dut%0d cycle %0d got %0h want %0h", name, k, cy, got, want);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        exp_t x;
        logic [7:0] gd[NDUT];
        logic [2:0] gc[NDUT];
        logic       gv[NDUT];
        logic       gw[NDUT];
        x = exp_q.pop_front();
        gd[0] = {4'h0, dout_a}; gc[0] = {1'b0, cur_a}; gv[0] = valid_a; gw[0] = wrap_a;
        gd[1] = dout_b;         gc[1] = cur_b;         gv[1] = valid_b; gw[1] = wrap_b;
        gd[2] = {4'h0, dout_c}; gc[2] = {1'b0, cur_c}; gv[2] = valid_c; gw[2] = wrap_c;
        for (int k = 0; k < NDUT; k++) begin
          check("dout",     k, x.cyc, int'(gd[k]), int'(x.dout[k]));
          check("cur_code", k, x.cyc, int'(gc[k]), int'(x.cur[k]));
          check("valid",    k, x.cyc, int'(gv[k]), int'(x.valid[k]));
          check("wrap",     k, x.cyc, int'(gw[k]), int'(x.wrap[k]));
        end
      end
    end
  end

  // Driver: inputs change 1 time unit after the rising edge; the model is advanced
  // with the inputs that were sampled at that edge.
  initial begin
    int hold;
    int off_left;
    hold     = 3;
    off_left = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    mode     = 1'b1;
    load     = 1'b0;
    code     = '0;
    model_reset();
    for (int i = 0; i < NCYC; i++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst_n) model_step(en, mode, load, int'(code));
      else       model_reset();
      if (rst_n && $urandom_range(0, 199) == 0) begin
        // Asynchronous reset between edges: outputs must clear before the next edge.
        rst_n = 1'b0;
        model_reset();
        hold = 1 + $urandom_range(0, 2);
      end else if (!rst_n) begin
        hold--;
        if (hold <= 0) rst_n = 1'b1;
      end
      exp_q.push_back(make_exp(cyc));

      if (off_left > 0) begin
        off_left--;
        en = 1'b0;
      end else if ($urandom_range(0, 99) < 4) begin
        off_left = $urandom_range(0, 5);
        en = 1'b0;
      end else begin
        en = 1'b1;
      end
      if ($urandom_range(0, 99) < 3) mode = ~mode;
      load = ($urandom_range(0, 99) < 12);
      code = 3'($urandom_range(0, 7));
    end
    load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
